// File: rtl/vtx_instr_tracker_pkg.sv
// Shared definitions for the coprocessor instruction tracker.
//   - tracker FSM state encoding
//   - architectural widths: XLEN, BEN_W, RESULT_W
package vtx_pkg;

    localparam int XLEN     = 32;
    localparam int BEN_W    = 4;
    localparam int RESULT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_REPORT = 2'd2
    } vtx_state_e;

endpackage

// File: rtl/vtx_instr_tracker_if.sv
// Observed CPU/coprocessor/memory signal bundle.
//   master : whoever drives the instruction and memory interfaces
//   slave  : the tracker, which only observes
//   NREGS  : coprocessor registers carried on cprs (register i at [i*32+:32])
interface vtx_instr_tracker_if
    import vtx_pkg::*;
#(
    parameter int NREGS = 16
);
    logic                  cpu_insn_req;
    logic                  cpu_insn_ack;
    logic [XLEN-1:0]       cpu_insn_enc;
    logic [XLEN-1:0]       cpu_rs1;
    logic [XLEN-1:0]       cpu_rs2;
    logic                  cop_insn_rsp;
    logic                  cop_insn_ack;
    logic [RESULT_W-1:0]   cop_result;
    logic                  cop_wen;
    logic [4:0]            cop_waddr;
    logic [XLEN-1:0]       cop_wdata;
    logic [NREGS*XLEN-1:0] cprs;
    logic                  mem_cen;
    logic                  mem_wen;
    logic                  mem_stall;
    logic [XLEN-1:0]       mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [BEN_W-1:0]      mem_ben;
    logic [XLEN-1:0]       mem_rdata;
    logic                  mem_error;

    modport master (
        output cpu_insn_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1, cpu_rs2,
        output cop_insn_rsp, cop_insn_ack, cop_result, cop_wen, cop_waddr, cop_wdata,
        output cprs,
        output mem_cen, mem_wen, mem_stall, mem_addr, mem_wdata, mem_ben,
        output mem_rdata, mem_error
    );

    modport slave (
        input cpu_insn_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1, cpu_rs2,
        input cop_insn_rsp, cop_insn_ack, cop_result, cop_wen, cop_waddr, cop_wdata,
        input cprs,
        input mem_cen, mem_wen, mem_stall, mem_addr, mem_wdata, mem_ben,
        input mem_rdata, mem_error
    );

endinterface

// File: rtl/vtx_instr_tracker_txn_log.sv
// Per-instruction memory transaction log.
//   i_clk, i_resetn : clock, synchronous active-low reset
//   i_clear         : start of a new instruction, empties every slot
//   i_accept        : accepted memory request while an instruction is in flight
//   i_wen/i_addr/i_wdata/i_ben : request fields
//   i_rdata/i_error : response fields, valid the cycle after acceptance
//   o_*             : slot arrays, count and overflow flag
// Response data shows on the outputs in the cycle it arrives so that a record
// reported in that same cycle is already complete.
module vtx_txn_log
    import vtx_pkg::*;
#(
    parameter int MAX_TXN = 4,
    parameter int TXN_W   = $clog2(MAX_TXN + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic                      i_clear,
    input  logic                      i_accept,
    input  logic                      i_wen,
    input  logic [XLEN-1:0]           i_addr,
    input  logic [XLEN-1:0]           i_wdata,
    input  logic [BEN_W-1:0]          i_ben,
    input  logic [XLEN-1:0]           i_rdata,
    input  logic                      i_error,
    output logic [MAX_TXN-1:0]        o_cen,
    output logic [MAX_TXN-1:0]        o_wen,
    output logic [MAX_TXN-1:0]        o_error,
    output logic [MAX_TXN*XLEN-1:0]   o_addr,
    output logic [MAX_TXN*XLEN-1:0]   o_wdata,
    output logic [MAX_TXN*XLEN-1:0]   o_rdata,
    output logic [MAX_TXN*BEN_W-1:0]  o_ben,
    output logic [TXN_W-1:0]          o_count,
    output logic                      o_overflow
);

    localparam logic [TXN_W-1:0] MAX_CNT = TXN_W'(MAX_TXN);

    logic [MAX_TXN-1:0]       r_cen;
    logic [MAX_TXN-1:0]       r_wen;
    logic [MAX_TXN-1:0]       r_err;
    logic [MAX_TXN*XLEN-1:0]  r_addr;
    logic [MAX_TXN*XLEN-1:0]  r_wdata;
    logic [MAX_TXN*XLEN-1:0]  r_rdata;
    logic [MAX_TXN*BEN_W-1:0] r_ben;
    logic [TXN_W-1:0]         r_count;
    logic                     r_overflow;
    // one-hot slot awaiting its response beat; zero when nothing is pending
    logic [MAX_TXN-1:0]       r_pend_hot;

    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clear) begin
            r_cen      <= '0;
            r_wen      <= '0;
            r_err      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ben      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pend_hot <= '0;
        end else begin
            r_pend_hot <= '0;
            for (int j = 0; j < MAX_TXN; j++) begin
                if (r_pend_hot[j]) begin
                    r_rdata[j*XLEN +: XLEN] <= i_rdata;
                    r_err[j]                <= i_error;
                end
            end
            if (i_accept) begin
                if (r_count != MAX_CNT) begin
                    for (int j = 0; j < MAX_TXN; j++) begin
                        if (r_count == TXN_W'(j)) begin
                            r_cen[j]                  <= 1'b1;
                            r_wen[j]                  <= i_wen;
                            r_addr[j*XLEN +: XLEN]    <= i_addr;
                            r_wdata[j*XLEN +: XLEN]   <= i_wdata;
                            r_ben[j*BEN_W +: BEN_W]   <= i_ben;
                            r_pend_hot[j]             <= 1'b1;
                        end
                    end
                    r_count <= r_count + TXN_W'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_rdata = r_rdata;
        o_error = r_err;
        for (int j = 0; j < MAX_TXN; j++) begin
            if (r_pend_hot[j]) begin
                o_rdata[j*XLEN +: XLEN] = i_rdata;
                o_error[j]              = i_error;
            end
        end
    end

    assign o_cen      = r_cen;
    assign o_wen      = r_wen;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_ben      = r_ben;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/vtx_instr_tracker.sv
// Coprocessor instruction tracker: follows one instruction from issue to
// response, snapshots the register file before and after, logs its memory
// transactions and presents the whole record with a one-cycle vtx_valid.
//   g_clk, g_resetn : clock, synchronous active-low reset
//   bus (slave)     : observed CPU issue, coprocessor response, cprs, memory
//   vtx_reset       : high in the first cycle after reset release
//   vtx_valid       : record strobe; every vtx_* record output is valid with it
//   vtx_protocol_err: sticky, issue while busy or response while idle
// Optional build macro VTX_TRACKER_ASSERT_EN embeds formal assertions that the
// protocol-error and overflow flags never rise, plus a cover on vtx_valid.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an issue handshake
// ST_BUSY   | instruction in flight, logging memory transactions
// ST_REPORT | record complete, vtx_valid high, post snapshot is live cprs
module vtx_instr_tracker
    import vtx_pkg::*;
#(
    parameter int NREGS   = 16,
    parameter int MAX_TXN = 4,
    parameter int TXN_W   = $clog2(MAX_TXN + 1)
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    vtx_instr_tracker_if.slave        bus,
    output logic                      vtx_reset,
    output logic                      vtx_valid,
    output logic [XLEN-1:0]           vtx_instr_enc,
    output logic [XLEN-1:0]           vtx_instr_rs1,
    output logic [XLEN-1:0]           vtx_instr_rs2,
    output logic [XLEN-1:0]           vtx_instr_wdata,
    output logic [RESULT_W-1:0]       vtx_instr_result,
    output logic [4:0]                vtx_instr_waddr,
    output logic                      vtx_instr_wen,
    output logic [NREGS*XLEN-1:0]     vtx_cprs_pre,
    output logic [NREGS*XLEN-1:0]     vtx_cprs_post,
    output logic [MAX_TXN-1:0]        vtx_mem_cen,
    output logic [MAX_TXN-1:0]        vtx_mem_wen,
    output logic [MAX_TXN-1:0]        vtx_mem_error,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_addr,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_wdata,
    output logic [MAX_TXN*XLEN-1:0]   vtx_mem_rdata,
    output logic [MAX_TXN*BEN_W-1:0]  vtx_mem_ben,
    output logic [TXN_W-1:0]          vtx_txn_count,
    output logic                      vtx_txn_overflow,
    output logic                      vtx_protocol_err
);

    vtx_state_e r_state;
    vtx_state_e w_next;

    logic                  r_rst_d;
    logic [XLEN-1:0]       r_enc;
    logic [XLEN-1:0]       r_rs1;
    logic [XLEN-1:0]       r_rs2;
    logic [XLEN-1:0]       r_wdata;
    logic [RESULT_W-1:0]   r_result;
    logic [4:0]            r_waddr;
    logic                  r_wen;
    logic [NREGS*XLEN-1:0] r_pre;
    logic [NREGS*XLEN-1:0] r_post;
    logic                  r_perr;

    logic w_issue;
    logic w_accept;
    logic w_rsp;
    logic w_cap_issue;
    logic w_cap_rsp;
    logic w_cap_post;
    logic w_log_accept;
    logic w_perr_set;

    assign w_issue  = bus.cpu_insn_req & bus.cpu_insn_ack;
    assign w_accept = bus.mem_cen & ~bus.mem_stall;
    assign w_rsp    = bus.cop_insn_rsp & bus.cop_insn_ack;

    always_comb begin
        w_next       = r_state;
        w_cap_issue  = 1'b0;
        w_cap_rsp    = 1'b0;
        w_cap_post   = 1'b0;
        w_log_accept = 1'b0;
        w_perr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_cap_issue = 1'b1;
                    w_next      = ST_BUSY;
                end
                if (w_rsp) w_perr_set = 1'b1;
            end
            ST_BUSY: begin
                w_log_accept = w_accept;
                if (w_issue) w_perr_set = 1'b1;
                if (w_rsp) begin
                    w_cap_rsp = 1'b1;
                    w_next    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_cap_post = 1'b1;
                w_next     = ST_IDLE;
                // back-to-back instructions: issue here is the next record
                if (w_issue) begin
                    w_cap_issue = 1'b1;
                    w_next      = ST_BUSY;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state  <= ST_IDLE;
            r_rst_d  <= 1'b1;
            r_enc    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_waddr  <= '0;
            r_wen    <= 1'b0;
            r_pre    <= '0;
            r_post   <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rst_d <= 1'b0;
            if (w_cap_issue) begin
                r_enc <= bus.cpu_insn_enc;
                r_rs1 <= bus.cpu_rs1;
                r_rs2 <= bus.cpu_rs2;
                r_pre <= bus.cprs;
            end
            if (w_cap_rsp) begin
                r_result <= bus.cop_result;
                r_wen    <= bus.cop_wen;
                r_waddr  <= bus.cop_waddr;
                r_wdata  <= bus.cop_wdata;
            end
            if (w_cap_post) r_post <= bus.cprs;
            if (w_perr_set) r_perr <= 1'b1;
        end
    end

    vtx_txn_log #(
        .MAX_TXN (MAX_TXN),
        .TXN_W   (TXN_W)
    ) u_txn_log (
        .i_clk      (g_clk),
        .i_resetn   (g_resetn),
        .i_clear    (w_cap_issue),
        .i_accept   (w_log_accept),
        .i_wen      (bus.mem_wen),
        .i_addr     (bus.mem_addr),
        .i_wdata    (bus.mem_wdata),
        .i_ben      (bus.mem_ben),
        .i_rdata    (bus.mem_rdata),
        .i_error    (bus.mem_error),
        .o_cen      (vtx_mem_cen),
        .o_wen      (vtx_mem_wen),
        .o_error    (vtx_mem_error),
        .o_addr     (vtx_mem_addr),
        .o_wdata    (vtx_mem_wdata),
        .o_rdata    (vtx_mem_rdata),
        .o_ben      (vtx_mem_ben),
        .o_count    (vtx_txn_count),
        .o_overflow (vtx_txn_overflow)
    );

    // r_rst_d survives from the reset cycles; gating with g_resetn keeps the
    // output low during reset and high only in the first released cycle.
    assign vtx_reset        = r_rst_d & g_resetn;
    assign vtx_valid        = (r_state == ST_REPORT);
    // the post snapshot is the cprs of the reporting cycle itself
    assign vtx_cprs_post    = w_cap_post ? bus.cprs : r_post;
    assign vtx_cprs_pre     = r_pre;
    assign vtx_instr_enc    = r_enc;
    assign vtx_instr_rs1    = r_rs1;
    assign vtx_instr_rs2    = r_rs2;
    assign vtx_instr_wdata  = r_wdata;
    assign vtx_instr_result = r_result;
    assign vtx_instr_waddr  = r_waddr;
    assign vtx_instr_wen    = r_wen;
    assign vtx_protocol_err = r_perr;

`ifdef VTX_TRACKER_ASSERT_EN
    a_no_protocol_err: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !$rose(vtx_protocol_err));
    a_no_overflow: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !$rose(vtx_txn_overflow));
    c_valid: cover property (@(posedge g_clk) disable iff (!g_resetn) vtx_valid);
`else
`endif

endmodule
